// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned WORD_BYTES = 4;
   localparam logic [5:0]  OPC_J      = 6'h02;
   localparam logic [5:0]  OPC_JAL    = 6'h03;

   // One buffered fetch: the word together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // J/JAL target: region bits of the delay-slot PC joined with the word index.
   function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc_plus4,
                                                   input logic [XLEN-1:0] instr);
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

   function automatic logic is_jump(input logic [XLEN-1:0] instr);
      return (instr[31:26] == OPC_J) || (instr[31:26] == OPC_JAL);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer with registered head; flush drops all entries and freezes the head outputs.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  fetch_entry_t       wdata,
   output logic               full_c,
   output logic               head_load_c,
   output logic [XLEN-1:0]    head_next_pc_c,
   output fetch_entry_t       head,
   output logic               head_vld
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
   logic [CNT_W-1:0] count, count_after_pop, count_next;
   logic             push_eff, pop_eff;
   fetch_entry_t     head_next;

   // Occupancy bookkeeping and the value the head register takes after this edge.
   always_comb begin
      full_c          = (count == CNT_W'(DEPTH));
      pop_eff         = pop && (count != '0) && !flush;
      push_eff        = push && !flush && (!full_c || pop_eff);
      count_after_pop = count - CNT_W'(pop_eff);
      count_next      = count_after_pop + CNT_W'(push_eff);
      rd_next         = rd_ptr + PTR_W'(pop_eff);
      // An entry written into an otherwise empty buffer becomes the head directly.
      head_next       = (count_after_pop == '0) ? wdata : mem[rd_next];
      head_load_c     = !flush && (count_next != '0);
      head_next_pc_c  = head_next.pc;
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_eff) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head     <= '0;
         head_vld <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head_vld <= 1'b0;
      end else begin
         rd_ptr   <= rd_next;
         wr_ptr   <= wr_ptr + PTR_W'(push_eff);
         count    <= count_next;
         head_vld <= (count_next != '0);
         if (head_load_c) begin
            head <= head_next;
         end
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch initiator: owns the PC, pre-decodes J/JAL and buffers words for decode.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_adr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_vld,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_vld,
   input  logic            inst_rdy,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_link
);

   localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(WORD_BYTES) - XLEN'(1));

   logic [XLEN-1:0] fetch_pc, pc_plus4, pc_next, link, head_next_pc;
   logic            pop, push, full, head_load, head_vld;
   fetch_entry_t    wdata, head;

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (push),
      .pop            (pop),
      .flush          (redirect_vld),
      .wdata          (wdata),
      .full_c         (full),
      .head_load_c    (head_load),
      .head_next_pc_c (head_next_pc),
      .head           (head),
      .head_vld       (head_vld)
   );

   // Next fetch address: redirect beats pre-decoded jump beats sequential.
   always_comb begin
      pc_plus4    = fetch_pc + XLEN'(WORD_BYTES);
      pop         = head_vld && inst_rdy;
      push        = (!full || pop) && !redirect_vld;
      wdata.pc    = fetch_pc;
      wdata.instr = imem_data;
      pc_next     = fetch_pc;
      if (redirect_vld) begin
         pc_next = redirect_pc & WORD_MASK;
      end else if (push) begin
         pc_next = is_jump(imem_data) ? jump_target(pc_plus4, imem_data) : pc_plus4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         link     <= '0;
      end else begin
         fetch_pc <= pc_next;
         if (head_load) begin
            link <= head_next_pc + XLEN'(WORD_BYTES);
         end
      end
   end

   assign imem_adr  = fetch_pc;
   assign inst_vld  = head_vld;
   assign inst      = head.instr;
   assign inst_pc   = head.pc;
   assign inst_link = link;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a byte-addressed little-endian instruction memory.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_adr, imem_data, redirect_pc, inst, inst_pc, inst_link;
   logic        redirect_vld = 1'b0;
   logic        inst_vld;
   logic        inst_rdy = 1'b0;

   logic [7:0]  imem [256];
   logic [7:0]  a;
   int          checks = 0;
   int          errors = 0;

   inst_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_adr     (imem_adr),
      .imem_data    (imem_data),
      .redirect_vld (redirect_vld),
      .redirect_pc  (redirect_pc),
      .inst_vld     (inst_vld),
      .inst_rdy     (inst_rdy),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .inst_link    (inst_link)
   );

   always #5 clk = ~clk;

   assign a = imem_adr[7:0];
   assign imem_data = {imem[a + 8'd3], imem[a + 8'd2], imem[a + 8'd1], imem[a]};

   function automatic logic [31:0] model_word(input logic [31:0] adr);
      logic [7:0] b;
      b = adr[7:0];
      return {imem[b + 8'd3], imem[b + 8'd2], imem[b + 8'd1], imem[b]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inst_rdy = 1'b1; redirect_vld = 1'b0; redirect_pc = '0;
      tick(); tick();
      checks++; if (imem_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected %h", imem_adr, 32'h0); end
      checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", inst_vld); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", inst_pc, 32'h0); end
      checks++; if (inst_link !== 32'h0) begin errors++; $display("FAIL reset_link: got %h expected %h", inst_link, 32'h0); end
      rst_n = 1'b1;
      tick();
      checks++; if (inst_vld !== 1'b1) begin errors++; $display("FAIL first_vld: got %b expected 1", inst_vld); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected %h", inst_pc, 32'h0); end
      checks++; if (inst !== model_word(32'h0)) begin errors++; $display("FAIL first_inst: got %h expected %h", inst, model_word(32'h0)); end
      checks++; if (imem_adr !== 32'h4) begin errors++; $display("FAIL first_adr: got %h expected %h", imem_adr, 32'h4); end
   endtask

   task automatic test_sequential();
      tick();
      checks++; if (inst_pc !== 32'h4 || inst_vld !== 1'b1) begin errors++; $display("FAIL seq_pc4: got %h/%b expected %h/1", inst_pc, inst_vld, 32'h4); end
      checks++; if (inst_link !== 32'h8) begin errors++; $display("FAIL seq_link4: got %h expected %h", inst_link, 32'h8); end
      tick();
      checks++; if (inst_pc !== 32'h8 || inst !== model_word(32'h8)) begin errors++; $display("FAIL seq_pc8: got %h/%h expected %h/%h", inst_pc, inst, 32'h8, model_word(32'h8)); end
   endtask

   task automatic test_jal();
      tick();
      checks++; if (inst_pc !== 32'hC || inst !== 32'h0C00_0006) begin errors++; $display("FAIL jal_head: got %h/%h expected %h/%h", inst_pc, inst, 32'hC, 32'h0C00_0006); end
      checks++; if (inst_link !== 32'h10) begin errors++; $display("FAIL jal_link: got %h expected %h", inst_link, 32'h10); end
      checks++; if (imem_adr !== 32'h18) begin errors++; $display("FAIL jal_target_adr: got %h expected %h", imem_adr, 32'h18); end
      tick();
      checks++; if (inst_pc !== 32'h18) begin errors++; $display("FAIL jal_next_head: got %h expected %h", inst_pc, 32'h18); end
      checks++; if (imem_adr !== 32'h1C) begin errors++; $display("FAIL jal_after_adr: got %h expected %h", imem_adr, 32'h1C); end
   endtask

   task automatic test_backpressure();
      rst_n = 1'b0; tick();
      rst_n = 1'b1; inst_rdy = 1'b0;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (inst_pc !== 32'h0 || inst_vld !== 1'b1) begin errors++; $display("FAIL bp_hold_head[%0d]: got %h/%b expected %h/1", i, inst_pc, inst_vld, 32'h0); end
         checks++; if (imem_adr !== 32'h8) begin errors++; $display("FAIL bp_hold_adr[%0d]: got %h expected %h", i, imem_adr, 32'h8); end
      end
      inst_rdy = 1'b1;
      tick();
      checks++; if (inst_pc !== 32'h4 || imem_adr !== 32'hC) begin errors++; $display("FAIL bp_rel1: got %h/%h expected %h/%h", inst_pc, imem_adr, 32'h4, 32'hC); end
      tick();
      checks++; if (inst_pc !== 32'h8 || imem_adr !== 32'h18) begin errors++; $display("FAIL bp_rel2: got %h/%h expected %h/%h", inst_pc, imem_adr, 32'h8, 32'h18); end
      tick();
      checks++; if (inst_pc !== 32'hC || imem_adr !== 32'h1C) begin errors++; $display("FAIL bp_rel3: got %h/%h expected %h/%h", inst_pc, imem_adr, 32'hC, 32'h1C); end
   endtask

   task automatic test_redirect();
      inst_rdy = 1'b0;
      tick();
      checks++; if (inst_pc !== 32'hC || imem_adr !== 32'h1C) begin errors++; $display("FAIL rd_full_hold: got %h/%h expected %h/%h", inst_pc, imem_adr, 32'hC, 32'h1C); end
      redirect_vld = 1'b1; redirect_pc = 32'h43; inst_rdy = 1'b1;
      tick();
      checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL rd_flush_vld: got %b expected 0", inst_vld); end
      checks++; if (imem_adr !== 32'h40) begin errors++; $display("FAIL rd_adr: got %h expected %h", imem_adr, 32'h40); end
      checks++; if (inst_pc !== 32'hC) begin errors++; $display("FAIL rd_empty_hold: got %h expected %h", inst_pc, 32'hC); end
      redirect_vld = 1'b0;
      tick();
      checks++; if (inst_vld !== 1'b1 || inst_pc !== 32'h40) begin errors++; $display("FAIL rd_head: got %b/%h expected 1/%h", inst_vld, inst_pc, 32'h40); end
      checks++; if (inst !== model_word(32'h40) || imem_adr !== 32'h44) begin errors++; $display("FAIL rd_word: got %h/%h expected %h/%h", inst, imem_adr, model_word(32'h40), 32'h44); end
   endtask

   task automatic test_reset_mid();
      inst_rdy = 1'b0;
      tick();
      checks++; if (imem_adr !== 32'h48) begin errors++; $display("FAIL mid_fill_adr: got %h expected %h", imem_adr, 32'h48); end
      rst_n = 1'b0; redirect_vld = 1'b1; redirect_pc = 32'h100;
      tick();
      checks++; if (imem_adr !== 32'h0 || inst_vld !== 1'b0) begin errors++; $display("FAIL mid_reset_adr_vld: got %h/%b expected %h/0", imem_adr, inst_vld, 32'h0); end
      checks++; if (inst_pc !== 32'h0 || inst !== 32'h0 || inst_link !== 32'h0) begin errors++; $display("FAIL mid_reset_head: got %h/%h/%h expected 0/0/0", inst_pc, inst, inst_link); end
      rst_n = 1'b1; redirect_vld = 1'b0; inst_rdy = 1'b1;
      tick();
      checks++; if (inst_vld !== 1'b1 || inst_pc !== 32'h0 || imem_adr !== 32'h4) begin errors++; $display("FAIL mid_restart: got %b/%h/%h expected 1/%h/%h", inst_vld, inst_pc, imem_adr, 32'h0, 32'h4); end
   endtask

   task automatic test_wrap();
      redirect_vld = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      checks++; if (imem_adr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_adr: got %h expected %h", imem_adr, 32'hFFFF_FFFC); end
      redirect_vld = 1'b0;
      tick();
      checks++; if (inst_pc !== 32'hFFFF_FFFC || inst_link !== 32'h0) begin errors++; $display("FAIL wrap_head: got %h/%h expected %h/%h", inst_pc, inst_link, 32'hFFFF_FFFC, 32'h0); end
      checks++; if (inst !== 32'h2008_00FC || imem_adr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h/%h expected %h/%h", inst, imem_adr, 32'h2008_00FC, 32'h0); end
      tick();
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL wrap_after: got %h expected %h", inst_pc, 32'h0); end
   endtask

   initial begin
      // addi $8,$0,<addr> at every word; JAL to 24 at address 12.
      for (int w = 0; w < 256; w += 4) begin
         logic [31:0] word;
         word = (w == 12) ? 32'h0C00_0006 : (32'h2008_0000 | 32'(w));
         for (int b = 0; b < 4; b++) begin
            imem[w + b] = word[8*b +: 8];
         end
      end
      test_reset();
      test_sequential();
      test_jal();
      test_backpressure();
      test_redirect();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
